// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants: state encoding, S-box, round constants
// and the read-response record used by the key bank.
package aes_pkg;
  localparam int AES_KEY_W      = 128;
  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_IDX_W      = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  // Entry 0 is the most significant byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon_lut(input logic [AES_IDX_W-1:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef struct packed {
    logic                 vld;
    logic                 err;
    logic [AES_KEY_W-1:0] key;
  } rd_rsp_t;
endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Key-load and round-key read bus between the encryption datapath and the key bank.
interface key_schedule_ctrl_if;
  import aes_pkg::*;

  logic [AES_KEY_W-1:0] key_in;
  logic                 key_load;
  logic                 key_busy;
  logic                 keys_ready;
  logic                 rd_en;
  logic [AES_IDX_W-1:0] rd_idx;
  logic                 rd_valid;
  logic                 rd_err;
  logic [AES_KEY_W-1:0] rd_key;

  modport master (
    output key_in, key_load, rd_en, rd_idx,
    input  key_busy, keys_ready, rd_valid, rd_err, rd_key
  );

  modport slave (
    input  key_in, key_load, rd_en, rd_idx,
    output key_busy, keys_ready, rd_valid, rd_err, rd_key
  );
endinterface

// File: rtl/key_schedule_ctrl_step.sv
// Single AES-128 key-expansion round: g_function (RotWord/SubWord/RCON) and
// the word-chaining XORs that derive the next round key.
module g_function
  import aes_pkg::*;
(
  input  logic [31:0] w,
  input  logic [7:0]  rcon,
  output logic [31:0] g
);
  logic [3:0][7:0] rot, sub;

  assign rot = {w[23:0], w[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign sub[i] = sbox(rot[i]);
  end

  assign g = sub ^ {rcon, 24'h0};
endmodule

module key_round_step
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] prev_key,
  input  logic [7:0]           rcon,
  output logic [AES_KEY_W-1:0] next_key
);
  logic [31:0] w0, w1, w2, w3, g, w4, w5, w6, w7;

  assign {w0, w1, w2, w3} = prev_key;

  g_function u_g (.w(w3), .rcon(rcon), .g(g));

  assign w4 = w0 ^ g;
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;
  assign next_key = {w4, w5, w6, w7};
endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule sequencer: expands one round per cycle into an 11-entry
// bank and serves round keys by index with a registered, 1-cycle read port.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int BLOCK_LENGTH = AES_KEY_W,
  parameter int NUM_ROUNDS   = AES_NUM_ROUNDS,
  parameter int IDX_W        = AES_IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  key_schedule_ctrl_if.slave  bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  logic [1:0]                              state;
  logic [IDX_W-1:0]                        round, prev_idx;
  logic [NUM_ROUNDS:0][BLOCK_LENGTH-1:0]   bank;
  logic [BLOCK_LENGTH-1:0]                 step_key;
  rd_rsp_t                                 rsp;
  logic                                    rd_acc, rd_bad;

  // round is 0 only outside EXPAND, where the step output is unused.
  assign prev_idx = (round == '0) ? '0 : round - 1'b1;

  key_round_step u_step (
    .prev_key (bank[prev_idx]),
    .rcon     (rcon_lut(round)),
    .next_key (step_key)
  );

  assign rd_acc = bus.rd_en && (state == ST_READY);
  assign rd_bad = bus.rd_idx > LAST_IDX;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      round <= '0;
      bank  <= '0;
      rsp   <= '0;
    end else begin
      // Read samples the bank before any same-cycle reload touches it.
      rsp.vld <= rd_acc;
      rsp.err <= rd_acc && rd_bad;
      if (rd_acc) rsp.key <= rd_bad ? '0 : bank[bus.rd_idx];

      if (bus.key_load) begin
        bank[0] <= bus.key_in;
        round   <= IDX_W'(1);
        state   <= ST_EXPAND;
      end else begin
        case (state)
          ST_EXPAND: begin
            bank[round] <= step_key;
            if (round == LAST_IDX) begin
              state <= ST_READY;
              round <= '0;
            end else begin
              round <= round + 1'b1;
            end
          end
          ST_IDLE, ST_READY: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.key_busy   = (state == ST_EXPAND);
  assign bus.keys_ready = (state == ST_READY);
  assign bus.rd_valid   = rsp.vld;
  assign bus.rd_err     = rsp.err;
  assign bus.rd_key     = rsp.key;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl: known FIPS-197 / all-zero schedules,
// restart, reset mid-expansion and read/load collision, with a read scoreboard.
module tb_key_schedule_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct packed {
    logic         err;
    logic [127:0] key;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_schedule_ctrl_if bus ();
  key_schedule_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] last_key = '0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_key(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
  endtask

  // Entered in cycle 1 after a load; returns at the negedge of cycle 11.
  task automatic expect_expansion(input string tag);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check_bit($sformatf("%s_busy_c%0d", tag, c), bus.key_busy, 1'b1);
      check_bit($sformatf("%s_ready_c%0d", tag, c), bus.keys_ready, 1'b0);
      tick();
    end
    @(negedge clk);
    check_bit($sformatf("%s_ready_c11", tag), bus.keys_ready, 1'b1);
    check_bit($sformatf("%s_busy_c11", tag), bus.key_busy, 1'b0);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp_key, input logic err);
    bus.rd_en  = 1'b1;
    bus.rd_idx = idx;
    exp_q.push_back('{err: err, key: exp_key});
    last_key = exp_key;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic rd_ignored(input string tag, input logic [3:0] idx);
    bus.rd_en  = 1'b1;
    bus.rd_idx = idx;
    tick();
    bus.rd_en = 1'b0;
    @(negedge clk);
    check_bit({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
    check_bit({tag, "_rd_err"}, bus.rd_err, 1'b0);
    check_key({tag, "_rd_key_held"}, bus.rd_key, last_key);
  endtask

  // Scoreboard monitor: every rd_valid must match the oldest expected read.
  always @(negedge clk) begin
    if (rst && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no read at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_key("rd_key", bus.rd_key, e.key);
        check_bit("rd_err", bus.rd_err, e.err);
      end
    end else if (rst && bus.rd_err) begin
      checks++;
      errors++;
      $display("FAIL rd_err_without_valid: got 1 expected 0 at %0t", $time);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.key_in   = '0;
    bus.key_load = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_idx   = '0;

    // Reset state, with key_load/rd_en asserted to show reset wins.
    bus.key_load = 1'b1;
    bus.rd_en    = 1'b1;
    tick();
    tick();
    bus.key_load = 1'b0;
    bus.rd_en    = 1'b0;
    @(negedge clk);
    check_bit("rst_busy", bus.key_busy, 1'b0);
    check_bit("rst_ready", bus.keys_ready, 1'b0);
    check_bit("rst_rd_valid", bus.rd_valid, 1'b0);
    check_bit("rst_rd_err", bus.rd_err, 1'b0);
    check_key("rst_rd_key", bus.rd_key, '0);
    rst = 1'b1;

    // FIPS-197 schedule and boundary indices.
    load_key(FIPS_K0);
    expect_expansion("fips");
    rd(4'd0, FIPS_K0, 1'b0);
    rd(4'd1, FIPS_K1, 1'b0);
    rd(4'd2, FIPS_K2, 1'b0);
    rd(4'd10, FIPS_K10, 1'b0);
    rd(4'd11, '0, 1'b1);
    rd(4'd15, '0, 1'b1);
    rd(4'd10, FIPS_K10, 1'b0);

    // Read/load collision: old key 0 returned, restart proceeds with all-zero key.
    bus.key_in   = '0;
    bus.key_load = 1'b1;
    bus.rd_en    = 1'b1;
    bus.rd_idx   = 4'd0;
    exp_q.push_back('{err: 1'b0, key: FIPS_K0});
    last_key = FIPS_K0;
    tick();
    bus.key_load = 1'b0;
    bus.rd_en    = 1'b0;
    expect_expansion("zero");
    rd(4'd1, ZERO_K1, 1'b0);
    rd(4'd10, ZERO_K10, 1'b0);
    rd(4'd0, '0, 1'b0);

    // Restart mid-expansion: FIPS key loaded in cycle 4 of an all-zero expansion.
    load_key('0);
    tick();
    tick();
    tick();
    load_key(FIPS_K0);
    expect_expansion("restart");
    rd(4'd10, FIPS_K10, 1'b0);
    rd(4'd1, FIPS_K1, 1'b0);

    // Read during EXPAND is ignored, then reset in cycle 6.
    load_key('0);
    rd_ignored("expand", 4'd3);
    tick();
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_bit("midrst_busy", bus.key_busy, 1'b0);
    check_bit("midrst_ready", bus.keys_ready, 1'b0);
    check_bit("midrst_rd_valid", bus.rd_valid, 1'b0);
    last_key = '0;
    rd_ignored("post_rst", 4'd0);
    for (int i = 0; i < 12; i++) tick();
    check_bit("idle_ready", bus.keys_ready, 1'b0);
    rd_ignored("idle", 4'd10);

    // Recovery after reset.
    load_key(FIPS_K0);
    expect_expansion("reload");
    rd(4'd10, FIPS_K10, 1'b0);
    rd(4'd2, FIPS_K2, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    tick();
    check_bit("scoreboard_drained", exp_q.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
